e203_exu_oitf_ooo: RTL and testbench

//  Parametrised outstanding-instruction track FIFO for long-pipe instructions (LSU, MulDiv, FPU) in the EXU.

---
 rtl/e203_exu_oitf_ooo_pkg.sv | 32 +++
 rtl/e203_exu_oitf_ooo_if.sv | 58 +++++
 rtl/e203_exu_oitf_entry.sv | 65 ++++++
 rtl/e203_exu_oitf_ooo.sv | 121 ++++++++++++
 tb/tb_e203_exu_oitf_ooo.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/e203_exu_oitf_ooo_pkg.sv
// Shared types and default sizing for the out-of-order-completion OITF.
// Exports:
//   E203_OITF_DEPTH / E203_ITAG_WIDTH / E203_RFIDX_WIDTH / E203_PC_SIZE  default sizes
//   oitf_pld_t   per-entry payload latched at dispatch
//   oitf_reg_t   register reference (enable, fpu file, index) used by hazard checks
//   rf_match     true when a live entry writes the referenced register
package e203_exu_oitf_ooo_pkg;

    localparam int unsigned E203_OITF_DEPTH  = 4;
    localparam int unsigned E203_ITAG_WIDTH  = 2;
    localparam int unsigned E203_RFIDX_WIDTH = 5;
    localparam int unsigned E203_PC_SIZE     = 32;

    typedef struct packed {
        logic                        rdwen;
        logic                        rdfpu;
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic [E203_PC_SIZE-1:0]     pc;
    } oitf_pld_t;

    typedef struct packed {
        logic                        en;
        logic                        fpu;
        logic [E203_RFIDX_WIDTH-1:0] idx;
    } oitf_reg_t;

    // Hazard regardless of done: the RF is only written at retire.
    function automatic logic rf_match(input logic vld, input oitf_pld_t pld, input oitf_reg_t r);
        return vld & pld.rdwen & r.en & (pld.rdfpu == r.fpu) & (pld.rdidx == r.idx);
    endfunction

endpackage

// File: rtl/e203_exu_oitf_ooo_if.sv
// Dispatch / commit / retire / status bundle of the OITF.
// slave  : OITF side (dispatch, commit, retire-ready, flush in; status, matches, head payload out)
// master : pipeline side (mirror of slave)
interface e203_exu_oitf_ooo_if
    import e203_exu_oitf_ooo_pkg::*;
#(
    parameter int unsigned ITAG_W = E203_ITAG_WIDTH
) ();
    logic                        dis_ena;
    logic                        dis_ready;
    logic [ITAG_W-1:0]           dis_ptr;
    logic                        disp_i_rdwen;
    logic                        disp_i_rdfpu;
    logic [E203_RFIDX_WIDTH-1:0] disp_i_rdidx;
    logic [E203_PC_SIZE-1:0]     disp_i_pc;
    logic                        disp_i_rs1en, disp_i_rs2en, disp_i_rs3en;
    logic                        disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu;
    logic [E203_RFIDX_WIDTH-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx;
    logic                        oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3;
    logic                        oitfrd_match_disprd;
    logic                        cmt_ena;
    logic [ITAG_W-1:0]           cmt_tag;
    logic                        ret_valid;
    logic                        ret_ready;
    logic [ITAG_W-1:0]           ret_ptr;
    logic [E203_RFIDX_WIDTH-1:0] ret_rdidx;
    logic                        ret_rdwen;
    logic                        ret_rdfpu;
    logic [E203_PC_SIZE-1:0]     ret_pc;
    logic                        flush_req;
    logic                        oitf_empty;
    logic                        oitf_full;
    logic [ITAG_W:0]             oitf_cnt;

    modport slave (
        input  dis_ena, disp_i_rdwen, disp_i_rdfpu, disp_i_rdidx, disp_i_pc,
               disp_i_rs1en, disp_i_rs2en, disp_i_rs3en,
               disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu,
               disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx,
               cmt_ena, cmt_tag, ret_ready, flush_req,
        output dis_ready, dis_ptr,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
               ret_valid, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
               oitf_empty, oitf_full, oitf_cnt
    );

    modport master (
        output dis_ena, disp_i_rdwen, disp_i_rdfpu, disp_i_rdidx, disp_i_pc,
               disp_i_rs1en, disp_i_rs2en, disp_i_rs3en,
               disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu,
               disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx,
               cmt_ena, cmt_tag, ret_ready, flush_req,
        input  dis_ready, dis_ptr,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
               ret_valid, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
               oitf_empty, oitf_full, oitf_cnt
    );
endinterface

// File: rtl/e203_exu_oitf_entry.sv
// One OITF slot: vld/done flags, payload, and the four hazard comparators.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_flush                         squash the slot (highest priority)
//   i_dis_set                       allocate this slot and latch i_pld
//   i_ret_clr                       slot retires (overridden by i_dis_set)
//   i_cmt_set                       completion aimed at this slot
//   i_rs1/2/3, i_rd                 dispatching register references
//   o_vld, o_done, o_pld            registered slot state
//   o_match_rs1/2/3_c, o_match_rd_c combinational hazard hits
module e203_exu_oitf_entry
    import e203_exu_oitf_ooo_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_flush,
    input  logic      i_dis_set,
    input  logic      i_ret_clr,
    input  logic      i_cmt_set,
    input  oitf_pld_t i_pld,
    input  oitf_reg_t i_rs1,
    input  oitf_reg_t i_rs2,
    input  oitf_reg_t i_rs3,
    input  oitf_reg_t i_rd,
    output logic      o_vld,
    output logic      o_done,
    output oitf_pld_t o_pld,
    output logic      o_match_rs1_c,
    output logic      o_match_rs2_c,
    output logic      o_match_rs3_c,
    output logic      o_match_rd_c
);
    logic      r_vld;
    logic      r_done;
    oitf_pld_t r_pld;

    // Slot state; a same-cycle dispatch wins over the retire clear (bypass reuse of the head slot).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_done <= 1'b0;
            r_pld  <= '0;
        end else if (i_flush) begin
            r_vld  <= 1'b0;
            r_done <= 1'b0;
        end else if (i_dis_set) begin
            r_vld  <= 1'b1;
            r_done <= 1'b0;
            r_pld  <= i_pld;
        end else begin
            if (i_ret_clr)
                r_vld <= 1'b0;
            if (i_cmt_set && r_vld)
                r_done <= 1'b1;
        end
    end

    assign o_vld         = r_vld;
    assign o_done        = r_done;
    assign o_pld         = r_pld;
    assign o_match_rs1_c = rf_match(r_vld, r_pld, i_rs1);
    assign o_match_rs2_c = rf_match(r_vld, r_pld, i_rs2);
    assign o_match_rs3_c = rf_match(r_vld, r_pld, i_rs3);
    assign o_match_rd_c  = rf_match(r_vld, r_pld, i_rd);
endmodule

// File: rtl/e203_exu_oitf_ooo.sv
// Outstanding-instruction track FIFO: in-order allocate, out-of-order complete by ITAG,
// in-order retire with valid/ready, hazard match, flush and occupancy count.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   io_oitf      e203_exu_oitf_ooo_if.slave (dispatch, commit, retire, flush, status)
// Option macro E203_OITF_RET_BYPASS_EN: when full, a retiring head slot may be re-allocated
// in the same cycle (dis_ready depends on ret_ready). Undefined by default.
module e203_exu_oitf_ooo
    import e203_exu_oitf_ooo_pkg::*;
#(
    parameter int unsigned OITF_DEPTH = E203_OITF_DEPTH,
    parameter int unsigned ITAG_W     = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1
) (
    input logic               clk,
    input logic               rst_n,
    e203_exu_oitf_ooo_if.slave io_oitf
);
    localparam int unsigned CNT_W = ITAG_W + 1;

    logic [ITAG_W-1:0]     r_alc_ptr, r_ret_ptr;
    logic                  r_alc_flg, r_ret_flg;
    logic [CNT_W-1:0]      r_cnt;

    logic [OITF_DEPTH-1:0] w_vld, w_done;
    logic [OITF_DEPTH-1:0] w_m_rs1, w_m_rs2, w_m_rs3, w_m_rd;
    oitf_pld_t             w_pld [OITF_DEPTH];
    oitf_pld_t             w_pld_in, w_head;
    oitf_reg_t             w_rs1, w_rs2, w_rs3, w_rd;
    logic                  w_empty, w_full, w_ret_valid, w_ret_hsk, w_dis_ready, w_dis;

    // Wrap at OITF_DEPTH-1 (depth need not be a power of two), toggling the lap flag.
    function automatic logic [ITAG_W:0] ptr_inc(input logic flg, input logic [ITAG_W-1:0] ptr);
        if (ptr == ITAG_W'(OITF_DEPTH - 1))
            return {~flg, {ITAG_W{1'b0}}};
        return {flg, ptr + ITAG_W'(1)};
    endfunction

    assign w_empty     = (r_alc_ptr == r_ret_ptr) && (r_alc_flg == r_ret_flg);
    assign w_full      = (r_alc_ptr == r_ret_ptr) && (r_alc_flg != r_ret_flg);
    assign w_ret_valid = w_vld[r_ret_ptr] & w_done[r_ret_ptr];
    assign w_ret_hsk   = w_ret_valid & io_oitf.ret_ready & ~io_oitf.flush_req;
`ifdef E203_OITF_RET_BYPASS_EN
    assign w_dis_ready = ~w_full | (w_ret_valid & io_oitf.ret_ready);
`else
    assign w_dis_ready = ~w_full;
`endif
    assign w_dis       = io_oitf.dis_ena & w_dis_ready & ~io_oitf.flush_req;

    assign w_pld_in = {io_oitf.disp_i_rdwen, io_oitf.disp_i_rdfpu, io_oitf.disp_i_rdidx, io_oitf.disp_i_pc};
    assign w_rs1    = {io_oitf.disp_i_rs1en, io_oitf.disp_i_rs1fpu, io_oitf.disp_i_rs1idx};
    assign w_rs2    = {io_oitf.disp_i_rs2en, io_oitf.disp_i_rs2fpu, io_oitf.disp_i_rs2idx};
    assign w_rs3    = {io_oitf.disp_i_rs3en, io_oitf.disp_i_rs3fpu, io_oitf.disp_i_rs3idx};
    assign w_rd     = {io_oitf.disp_i_rdwen, io_oitf.disp_i_rdfpu, io_oitf.disp_i_rdidx};

    // Pointers, lap flags and occupancy; flush discards everything else in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alc_ptr <= '0;
            r_alc_flg <= 1'b0;
            r_ret_ptr <= '0;
            r_ret_flg <= 1'b0;
            r_cnt     <= '0;
        end else if (io_oitf.flush_req) begin
            r_alc_ptr <= '0;
            r_alc_flg <= 1'b0;
            r_ret_ptr <= '0;
            r_ret_flg <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_dis)
                {r_alc_flg, r_alc_ptr} <= ptr_inc(r_alc_flg, r_alc_ptr);
            if (w_ret_hsk)
                {r_ret_flg, r_ret_ptr} <= ptr_inc(r_ret_flg, r_ret_ptr);
            if (w_dis && !w_ret_hsk)
                r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_dis && w_ret_hsk)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_ent
        e203_exu_oitf_entry u_ent (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_flush       (io_oitf.flush_req),
            .i_dis_set     (w_dis && (r_alc_ptr == ITAG_W'(i))),
            .i_ret_clr     (w_ret_hsk && (r_ret_ptr == ITAG_W'(i))),
            .i_cmt_set     (io_oitf.cmt_ena && (io_oitf.cmt_tag == ITAG_W'(i))),
            .i_pld         (w_pld_in),
            .i_rs1         (w_rs1),
            .i_rs2         (w_rs2),
            .i_rs3         (w_rs3),
            .i_rd          (w_rd),
            .o_vld         (w_vld[i]),
            .o_done        (w_done[i]),
            .o_pld         (w_pld[i]),
            .o_match_rs1_c (w_m_rs1[i]),
            .o_match_rs2_c (w_m_rs2[i]),
            .o_match_rs3_c (w_m_rs3[i]),
            .o_match_rd_c  (w_m_rd[i])
        );
    end

    assign w_head = w_pld[r_ret_ptr];

    assign io_oitf.dis_ready            = w_dis_ready;
    assign io_oitf.dis_ptr              = r_alc_ptr;
    assign io_oitf.ret_valid            = w_ret_valid;
    assign io_oitf.ret_ptr              = r_ret_ptr;
    assign io_oitf.ret_rdidx            = w_head.rdidx;
    assign io_oitf.ret_rdwen            = w_head.rdwen;
    assign io_oitf.ret_rdfpu            = w_head.rdfpu;
    assign io_oitf.ret_pc               = w_head.pc;
    assign io_oitf.oitfrd_match_disprs1 = |w_m_rs1;
    assign io_oitf.oitfrd_match_disprs2 = |w_m_rs2;
    assign io_oitf.oitfrd_match_disprs3 = |w_m_rs3;
    assign io_oitf.oitfrd_match_disprd  = |w_m_rd;
    assign io_oitf.oitf_empty           = w_empty;
    assign io_oitf.oitf_full            = w_full;
    assign io_oitf.oitf_cnt             = r_cnt;
endmodule

// File: tb/tb_e203_exu_oitf_ooo.sv
// Directed bench for e203_exu_oitf_ooo: a depth-4 instance for the main scenarios and a
// depth-3 instance for non-power-of-two wrap.
module tb_e203_exu_oitf_ooo;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    e203_exu_oitf_ooo_if #(.ITAG_W(2)) bus4 ();
    e203_exu_oitf_ooo_if #(.ITAG_W(2)) bus3 ();

    e203_exu_oitf_ooo #(.OITF_DEPTH(4), .ITAG_W(2)) u_dut4 (.clk(clk), .rst_n(rst_n), .io_oitf(bus4));
    e203_exu_oitf_ooo #(.OITF_DEPTH(3), .ITAG_W(2)) u_dut3 (.clk(clk), .rst_n(rst_n), .io_oitf(bus3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        bus4.dis_ena = 0; bus4.disp_i_rdwen = 0; bus4.disp_i_rdfpu = 0; bus4.disp_i_rdidx = '0;
        bus4.disp_i_pc = '0;
        bus4.disp_i_rs1en = 0; bus4.disp_i_rs2en = 0; bus4.disp_i_rs3en = 0;
        bus4.disp_i_rs1fpu = 0; bus4.disp_i_rs2fpu = 0; bus4.disp_i_rs3fpu = 0;
        bus4.disp_i_rs1idx = '0; bus4.disp_i_rs2idx = '0; bus4.disp_i_rs3idx = '0;
        bus4.cmt_ena = 0; bus4.cmt_tag = '0; bus4.ret_ready = 0; bus4.flush_req = 0;
    endtask

    task automatic idle3();
        bus3.dis_ena = 0; bus3.disp_i_rdwen = 0; bus3.disp_i_rdfpu = 0; bus3.disp_i_rdidx = '0;
        bus3.disp_i_pc = '0;
        bus3.disp_i_rs1en = 0; bus3.disp_i_rs2en = 0; bus3.disp_i_rs3en = 0;
        bus3.disp_i_rs1fpu = 0; bus3.disp_i_rs2fpu = 0; bus3.disp_i_rs3fpu = 0;
        bus3.disp_i_rs1idx = '0; bus3.disp_i_rs2idx = '0; bus3.disp_i_rs3idx = '0;
        bus3.cmt_ena = 0; bus3.cmt_tag = '0; bus3.ret_ready = 0; bus3.flush_req = 0;
    endtask

    // One integer-rd dispatch into the depth-4 instance.
    task automatic disp4(input int rd, input int pc);
        bus4.dis_ena = 1; bus4.disp_i_rdwen = 1; bus4.disp_i_rdfpu = 0;
        bus4.disp_i_rdidx = 5'(rd); bus4.disp_i_pc = 32'(pc);
        tick();
        bus4.dis_ena = 0;
    endtask

    task automatic cmt4(input int tag);
        bus4.cmt_ena = 1; bus4.cmt_tag = 2'(tag);
        tick();
        bus4.cmt_ena = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle4();
        idle3();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_empty", bus4.oitf_empty, 1);
        chk("rst_full", bus4.oitf_full, 0);
        chk("rst_cnt", bus4.oitf_cnt, 0);
        chk("rst_dis_ready", bus4.dis_ready, 1);
        chk("rst_ret_valid", bus4.ret_valid, 0);
        chk("rst_match_rd", bus4.oitfrd_match_disprd, 0);
        chk("rst3_empty", bus3.oitf_empty, 1);

        // Fill with rd=x1..x4, no commits
        for (int i = 0; i < 4; i++) begin
            chk("fill_dis_ptr", bus4.dis_ptr, 64'(i));
            disp4(i + 1, 'h100 + 4 * i);
        end
        chk("fill_full", bus4.oitf_full, 1);
        chk("fill_dis_ready", bus4.dis_ready, 0);
        chk("fill_cnt", bus4.oitf_cnt, 4);
        chk("fill_ret_valid", bus4.ret_valid, 0);
        chk("fill_empty", bus4.oitf_empty, 0);

        // Hazard comparators against the full, not-done FIFO
        bus4.disp_i_rs1en = 1; bus4.disp_i_rs1idx = 5'd3;
        bus4.disp_i_rs2en = 1; bus4.disp_i_rs2idx = 5'd9;
        bus4.disp_i_rdwen = 1; bus4.disp_i_rdidx = 5'd4; bus4.disp_i_rdfpu = 0;
        #1;
        chk("haz_rs1_x3", bus4.oitfrd_match_disprs1, 1);
        chk("haz_rs2_x9", bus4.oitfrd_match_disprs2, 0);
        chk("haz_rd_x4", bus4.oitfrd_match_disprd, 1);
        bus4.disp_i_rdfpu = 1;
        #1;
        chk("haz_rd_fpu", bus4.oitfrd_match_disprd, 0);
        idle4();

        // Out-of-order commits 2,0,3,1 with ret_ready held high
        bus4.ret_ready = 1;
        cmt4(2);
        chk("c2_ret_valid", bus4.ret_valid, 0);
        cmt4(0);
        chk("c0_ret_valid", bus4.ret_valid, 1);
        chk("c0_ret_ptr", bus4.ret_ptr, 0);
        chk("c0_ret_rdidx", bus4.ret_rdidx, 1);
        chk("c0_ret_pc", bus4.ret_pc, 'h100);
        cmt4(3);
        chk("c3_ret_valid", bus4.ret_valid, 0);
        chk("c3_ret_ptr", bus4.ret_ptr, 1);
        chk("c3_cnt", bus4.oitf_cnt, 3);
        chk("c3_dis_ready", bus4.dis_ready, 1);
        cmt4(1);
        chk("c1_ret_valid", bus4.ret_valid, 1);
        chk("c1_ret_ptr", bus4.ret_ptr, 1);
        tick();
        chk("r1_ret_valid", bus4.ret_valid, 1);
        chk("r1_ret_ptr", bus4.ret_ptr, 2);
        chk("r1_ret_rdidx", bus4.ret_rdidx, 3);
        tick();
        chk("r2_ret_ptr", bus4.ret_ptr, 3);
        chk("r2_ret_pc", bus4.ret_pc, 'h10c);
        chk("r2_ret_rdwen", bus4.ret_rdwen, 1);
        tick();
        chk("r3_empty", bus4.oitf_empty, 1);
        chk("r3_cnt", bus4.oitf_cnt, 0);
        chk("r3_ret_ptr", bus4.ret_ptr, 0);
        chk("r3_ret_valid", bus4.ret_valid, 0);
        bus4.ret_ready = 0;

        // RAW on x5: live and not done, fpu mismatch, done but not retired, retired
        disp4(5, 'h200);
        bus4.disp_i_rs1en = 1; bus4.disp_i_rs1idx = 5'd5;
        bus4.disp_i_rs3en = 1; bus4.disp_i_rs3idx = 5'd5;
        #1;
        chk("x5_rs1", bus4.oitfrd_match_disprs1, 1);
        chk("x5_rs3", bus4.oitfrd_match_disprs3, 1);
        bus4.disp_i_rs1fpu = 1;
        #1;
        chk("x5_rs1_fpu", bus4.oitfrd_match_disprs1, 0);
        bus4.disp_i_rs1fpu = 0;
        cmt4(0);
        chk("x5_done_rs1", bus4.oitfrd_match_disprs1, 1);
        chk("x5_done_valid", bus4.ret_valid, 1);
        bus4.ret_ready = 1;
        tick();
        bus4.ret_ready = 0;
        chk("x5_ret_rs1", bus4.oitfrd_match_disprs1, 0);
        chk("x5_ret_rs3", bus4.oitfrd_match_disprs3, 0);
        chk("x5_ret_empty", bus4.oitf_empty, 1);
        idle4();

        // Flush with simultaneous dispatch, commit and retire handshake
        for (int i = 0; i < 4; i++) disp4(6 + i, 'h300 + 4 * i);
        chk("fl_full", bus4.oitf_full, 1);
        cmt4(1);
        chk("fl_head_valid", bus4.ret_valid, 1);
        bus4.flush_req = 1; bus4.dis_ena = 1; bus4.disp_i_rdwen = 1; bus4.disp_i_rdidx = 5'd20;
        bus4.cmt_ena = 1; bus4.cmt_tag = 2'd2; bus4.ret_ready = 1;
        tick();
        idle4();
        #1;
        chk("fl_empty", bus4.oitf_empty, 1);
        chk("fl_full0", bus4.oitf_full, 0);
        chk("fl_cnt", bus4.oitf_cnt, 0);
        chk("fl_ret_ptr", bus4.ret_ptr, 0);
        chk("fl_dis_ptr", bus4.dis_ptr, 0);
        chk("fl_ret_valid", bus4.ret_valid, 0);
        bus4.disp_i_rs1en = 1; bus4.disp_i_rs1idx = 5'd7;
        #1;
        chk("fl_match", bus4.oitfrd_match_disprs1, 0);
        idle4();

        // Full with done head: dispatch and retire in the same cycle
        for (int i = 0; i < 4; i++) disp4(10 + i, 'h400 + 4 * i);
        cmt4(0);
        bus4.ret_ready = 1;
        #1;
        chk("byp_ret_valid", bus4.ret_valid, 1);
`ifdef E203_OITF_RET_BYPASS_EN
        chk("byp_dis_ready", bus4.dis_ready, 1);
`else
        chk("byp_dis_ready", bus4.dis_ready, 0);
`endif
        bus4.dis_ena = 1; bus4.disp_i_rdwen = 1; bus4.disp_i_rdidx = 5'd14;
        tick();
        idle4();
        #1;
        chk("byp_ret_ptr", bus4.ret_ptr, 1);
`ifdef E203_OITF_RET_BYPASS_EN
        chk("byp_cnt", bus4.oitf_cnt, 4);
        chk("byp_full", bus4.oitf_full, 1);
        chk("byp_dis_ptr", bus4.dis_ptr, 1);
`else
        chk("byp_cnt", bus4.oitf_cnt, 3);
        chk("byp_full", bus4.oitf_full, 0);
        chk("byp_dis_ptr", bus4.dis_ptr, 0);
`endif

        // Depth 3: seven single-entry rounds cross the 2->0 wrap twice
        for (int r = 0; r < 7; r++) begin
            bus3.dis_ena = 1; bus3.disp_i_rdwen = 1; bus3.disp_i_rdidx = 5'(r + 1);
            tick();
            bus3.dis_ena = 0;
            chk("d3_empty_after_dis", bus3.oitf_empty, 0);
            chk("d3_cnt", bus3.oitf_cnt, 1);
            chk("d3_dis_ptr", bus3.dis_ptr, 64'((r + 1) % 3));
            chk("d3_not_valid", bus3.ret_valid, 0);
            bus3.cmt_ena = 1; bus3.cmt_tag = 2'(r % 3);
            tick();
            bus3.cmt_ena = 0;
            chk("d3_valid", bus3.ret_valid, 1);
            chk("d3_head_rd", bus3.ret_rdidx, 64'(r + 1));
            bus3.ret_ready = 1;
            tick();
            bus3.ret_ready = 0;
            chk("d3_empty", bus3.oitf_empty, 1);
            chk("d3_not_full", bus3.oitf_full, 0);
            chk("d3_ret_ptr", bus3.ret_ptr, 64'((r + 1) % 3));
        end
        for (int i = 0; i < 3; i++) begin
            bus3.dis_ena = 1; bus3.disp_i_rdidx = 5'(20 + i);
            tick();
            bus3.dis_ena = 0;
        end
        chk("d3_full", bus3.oitf_full, 1);
        chk("d3_full_cnt", bus3.oitf_cnt, 3);
        chk("d3_full_ready", bus3.dis_ready, 0);
        chk("d3_full_ptr", bus3.dis_ptr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
